// File: rtl/tx_pattern_gen.sv
// tx_pattern_gen: 16-bit TX test-pattern source (zero / fixed / clock / PRBS7-15-31) with a
// handshaked, bit-masked error-injection port. Define TX_PATGEN_INJ_SYNC_EN to add a 2-flop inj_req synchronizer.

module tx_pattern_gen #(
   parameter int          WIDTH    = 16,
   parameter logic [30:0] SEED_DEF = 31'h7FFF_FFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [1:0]       prbs_sel,
   input  logic [30:0]      seed,
   input  logic [WIDTH-1:0] fixed_word,
   input  logic             inj_req,
   input  logic [WIDTH-1:0] inj_mask,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             inj_ack,
   output logic [15:0]      inj_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [1:0]       MODE_ZERO  = 2'b00;
   localparam logic [1:0]       MODE_FIXED = 2'b01;
   localparam logic [1:0]       MODE_CLOCK = 2'b10;
   localparam logic [1:0]       MODE_PRBS  = 2'b11;
   localparam logic [WIDTH-1:0] CLOCK_WORD = 16'hAAAA;

   // Active LFSR bits per polynomial; everything above is held at zero.
   function automatic logic [30:0] prbs_mask(input logic [1:0] sel);
      case (sel)
         2'b00:   return 31'h0000_007F;
         2'b01:   return 31'h0000_7FFF;
         default: return 31'h7FFF_FFFF;
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [1:0]         sel_q, sel_d;
   logic [30:0]        lfsr_q, lfsr_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic               inj_ack_q, inj_ack_d;
   logic [15:0]        inj_cnt_q, inj_cnt_d;
   logic               armed_q, armed_d;
   logic               inj_prev_q;

   logic               inj_src;
   logic               inj_rise;
   logic               produce;
   logic               inj_fire;
   logic               reseed_req;
   logic [30:0]        run_mask;
   logic [30:0]        load_mask;
   logic [30:0]        seed_masked;
   logic [30:0]        seed_load;
   logic [30:0]        lfsr_adv;
   logic [WIDTH-1:0]   prbs_word;
   logic [WIDTH-1:0]   pattern;
   logic               fb;

`ifdef TX_PATGEN_INJ_SYNC_EN
   logic [1:0] inj_sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inj_sync_q <= '0;
      end else begin
         inj_sync_q <= {inj_sync_q[0], inj_req};
      end
   end

   assign inj_src = inj_sync_q[1];
`else
   assign inj_src = inj_req;
`endif

   assign run_mask    = prbs_mask(sel_q);
   assign load_mask   = prbs_mask(prbs_sel);
   assign seed_masked = seed & load_mask;
   assign seed_load   = (seed_masked == '0) ? (SEED_DEF & load_mask) : seed_masked;
   assign reseed_req  = (mode != mode_q) || (prbs_sel != sel_q);

   always_comb begin : fsm_next
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (en) state_d = ST_LOAD;
         ST_LOAD: state_d = en ? ST_RUN : ST_IDLE;
         ST_RUN: begin
            if (!en)             state_d = ST_IDLE;
            else if (reseed_req) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sixteen Fibonacci steps per clock; the first generated bit lands in the MSB.
   always_comb begin : prbs_gen
      lfsr_adv  = lfsr_q;
      prbs_word = '0;
      fb        = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         unique case (sel_q)
            2'b00:   fb = lfsr_adv[6]  ^ lfsr_adv[5];
            2'b01:   fb = lfsr_adv[14] ^ lfsr_adv[13];
            default: fb = lfsr_adv[30] ^ lfsr_adv[27];
         endcase
         prbs_word[i] = fb;
         lfsr_adv     = {lfsr_adv[29:0], fb} & run_mask;
      end
   end

   always_comb begin : pattern_mux
      pattern = '0;
      unique case (mode_q)
         MODE_ZERO:  pattern = '0;
         MODE_FIXED: pattern = fixed_word;
         MODE_CLOCK: pattern = CLOCK_WORD;
         MODE_PRBS:  pattern = prbs_word;
         default:    pattern = '0;
      endcase
   end

   // A word is produced only on cycles that stay in RUN, so a reseed or stop beats injection.
   assign produce  = (state_q == ST_RUN) && (state_d == ST_RUN);
   assign inj_fire = produce && armed_q;
   assign inj_rise = inj_src && !inj_prev_q;

   always_comb begin : datapath_next
      mode_d       = mode_q;
      sel_d        = sel_q;
      lfsr_d       = lfsr_q;
      dout_d       = '0;
      dout_valid_d = 1'b0;
      inj_ack_d    = inj_fire;
      inj_cnt_d    = inj_cnt_q;
      armed_d      = inj_fire ? 1'b0 : (armed_q || inj_rise);

      if (state_q == ST_LOAD) begin
         mode_d = mode;
         sel_d  = prbs_sel;
         lfsr_d = seed_load;
      end else if (produce && (mode_q == MODE_PRBS)) begin
         lfsr_d = lfsr_adv;
      end

      if (produce) begin
         dout_valid_d = 1'b1;
         dout_d       = inj_fire ? (pattern ^ inj_mask) : pattern;
      end

      if (inj_fire && (inj_cnt_q != 16'hFFFF)) begin
         inj_cnt_d = inj_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_ZERO;
         sel_q        <= 2'b00;
         lfsr_q       <= SEED_DEF;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         inj_ack_q    <= 1'b0;
         inj_cnt_q    <= '0;
         armed_q      <= 1'b0;
         inj_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         sel_q        <= sel_d;
         lfsr_q       <= lfsr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         inj_ack_q    <= inj_ack_d;
         inj_cnt_q    <= inj_cnt_d;
         armed_q      <= armed_d;
         inj_prev_q   <= inj_src;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign inj_ack    = inj_ack_q;
   assign inj_cnt    = inj_cnt_q;

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Bench for tx_pattern_gen: mode table, PRBS streams against a bit-serial model,
// error injection, counter saturation, reseed/reset corner cases. Honors TX_PATGEN_INJ_SYNC_EN.

module tb_tx_pattern_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  mode;
   logic [1:0]  prbs_sel;
   logic [30:0] seed;
   logic [15:0] fixed_word;
   logic        inj_req;
   logic [15:0] inj_mask;
   logic [15:0] dout;
   logic        dout_valid;
   logic        inj_ack;
   logic [15:0] inj_cnt;

   always #5 clk = ~clk;

   tx_pattern_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .prbs_sel   (prbs_sel),
      .seed       (seed),
      .fixed_word (fixed_word),
      .inj_req    (inj_req),
      .inj_mask   (inj_mask),
      .dout       (dout),
      .dout_valid (dout_valid),
      .inj_ack    (inj_ack),
      .inj_cnt    (inj_cnt)
   );

`ifdef TX_PATGEN_INJ_SYNC_EN
   localparam int INJ_LAT = 3;
`else
   localparam int INJ_LAT = 1;
`endif

   typedef struct {
      logic [15:0] dout;
      logic        valid;
      logic        ack;
      string       tag;
   } exp_t;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] fixed;
      logic [15:0] word;
      string       name;
   } mode_vec_t;

   exp_t        exp_q[$];
   mode_vec_t   vecs[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [30:0] m_state;
   logic [30:0] m_mask;
   int          m_n;
   int          m_tap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: no expected entry at time %0t", $time);
      end else begin
         e = exp_q.pop_front();
         check({e.tag, ".dout"},  {16'h0, dout},       {16'h0, e.dout});
         check({e.tag, ".valid"}, {31'h0, dout_valid}, {31'h0, e.valid});
         check({e.tag, ".ack"},   {31'h0, inj_ack},    {31'h0, e.ack});
      end
   endtask

   task automatic expect_cycle(input logic [15:0] d, input logic v, input logic a, input string tag);
      exp_t e;
      e.dout  = d;
      e.valid = v;
      e.ack   = a;
      e.tag   = tag;
      exp_q.push_back(e);
      tick();
   endtask

   task automatic model_seed(input logic [1:0] sel, input logic [30:0] s);
      case (sel)
         2'b00:   begin m_n = 7;  m_tap = 6;  end
         2'b01:   begin m_n = 15; m_tap = 14; end
         default: begin m_n = 31; m_tap = 28; end
      endcase
      m_mask  = 31'h7FFF_FFFF >> (31 - m_n);
      m_state = s & m_mask;
      if (m_state == 0) m_state = m_mask;
   endtask

   // Bit-serial reference: one generated bit per step, oldest bit ends up in bit 15.
   task automatic model_word(output logic [15:0] w);
      logic b;
      w = '0;
      for (int k = 0; k < 16; k++) begin
         b       = m_state[m_n-1] ^ m_state[m_tap-1];
         m_state = ((m_state << 1) | {30'h0, b}) & m_mask;
         w       = {w[14:0], b};
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      en      = 1'b0;
      inj_req = 1'b0;
      expect_cycle(16'h0, 1'b0, 1'b0, "reset");
      check("reset.inj_cnt", {16'h0, inj_cnt}, 32'h0);
      rst_n = 1'b1;
   endtask

   task automatic start_run();
      en = 1'b1;
      expect_cycle(16'h0, 1'b0, 1'b0, "lat_n");
      expect_cycle(16'h0, 1'b0, 1'b0, "lat_n1");
   endtask

   task automatic prbs_words(input int n, input int inj_idx, input logic [15:0] mask,
                             input int req_len, input string tag);
      logic [15:0] w;
      bit          hit;
      if (req_len > 0) inj_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         model_word(w);
         hit = (i == inj_idx);
         expect_cycle(hit ? (w ^ mask) : w, 1'b1, hit, tag);
         if (i + 1 == req_len) inj_req = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      logic [15:0] w0;
      mode_vec_t   v;

      rst_n      = 1'b0;
      en         = 1'b0;
      mode       = 2'b00;
      prbs_sel   = 2'b00;
      seed       = '0;
      fixed_word = '0;
      inj_req    = 1'b0;
      inj_mask   = '0;

      v = '{mode: 2'b00, fixed: 16'hFFFF, word: 16'h0000, name: "zero"};   vecs.push_back(v);
      v = '{mode: 2'b01, fixed: 16'hA5C3, word: 16'hA5C3, name: "fixed"};  vecs.push_back(v);
      v = '{mode: 2'b10, fixed: 16'h1234, word: 16'hAAAA, name: "clock"};  vecs.push_back(v);
      v = '{mode: 2'b01, fixed: 16'h0001, word: 16'h0001, name: "fixed1"}; vecs.push_back(v);

      // Mode table: two zero words of latency, then the pattern, then zero after en drops.
      foreach (vecs[i]) begin
         do_reset();
         mode       = vecs[i].mode;
         fixed_word = vecs[i].fixed;
         start_run();
         repeat (3) expect_cycle(vecs[i].word, 1'b1, 1'b0, vecs[i].name);
         en = 1'b0;
         expect_cycle(16'h0, 1'b0, 1'b0, {vecs[i].name, ".stop"});
         expect_cycle(16'h0, 1'b0, 1'b0, {vecs[i].name, ".idle"});
      end

      // Clock pattern, then a mode change in RUN forces a reload.
      do_reset();
      mode = 2'b10;
      start_run();
      repeat (3) expect_cycle(16'hAAAA, 1'b1, 1'b0, "clock_run");
      mode       = 2'b01;
      fixed_word = 16'hA5C3;
      expect_cycle(16'h0, 1'b0, 1'b0, "reload_load");
      expect_cycle(16'h0, 1'b0, 1'b0, "reload_run0");
      expect_cycle(16'hA5C3, 1'b1, 1'b0, "reload_fixed");
      expect_cycle(16'hA5C3, 1'b1, 1'b0, "reload_fixed");
      fixed_word = 16'h5A5A;
      expect_cycle(16'h5A5A, 1'b1, 1'b0, "fixed_live");
      en = 1'b0;
      expect_cycle(16'h0, 1'b0, 1'b0, "stop");

      // en dropped while in LOAD goes straight back to IDLE.
      en = 1'b1;
      expect_cycle(16'h0, 1'b0, 1'b0, "load_abort_load");
      en = 1'b0;
      expect_cycle(16'h0, 1'b0, 1'b0, "load_abort_idle");
      expect_cycle(16'h0, 1'b0, 1'b0, "load_abort_idle2");
      start_run();
      expect_cycle(16'h5A5A, 1'b1, 1'b0, "after_abort");

      // PRBS7 from the default seed: matches the model, never zero, wraps after 127 words.
      do_reset();
      mode     = 2'b11;
      prbs_sel = 2'b00;
      seed     = '0;
      model_seed(2'b00, 31'h0);
      start_run();
      w0 = '0;
      for (int i = 0; i < 128; i++) begin
         model_word(w);
         if (i == 0) w0 = w;
         expect_cycle((i == 127) ? w0 : w, 1'b1, 1'b0, (i == 127) ? "prbs7_wrap" : "prbs7");
         check("prbs7_nonzero", {31'h0, (dout != 16'h0)}, 32'h1);
      end

      // Switching to PRBS15 reseeds from the low 15 seed bits.
      seed     = 31'h1234_5A5A;
      prbs_sel = 2'b01;
      expect_cycle(16'h0, 1'b0, 1'b0, "prbs15_load");
      expect_cycle(16'h0, 1'b0, 1'b0, "prbs15_run0");
      model_seed(2'b01, 31'h1234_5A5A);
      prbs_words(8, -1, 16'h0, 0, "prbs15");

      // PRBS31 single-bit injection: one corrupted word, stream intact, counter = 1.
      do_reset();
      mode     = 2'b11;
      prbs_sel = 2'b10;
      seed     = 31'h0123_4567;
      model_seed(2'b10, 31'h0123_4567);
      start_run();
      prbs_words(4, -1, 16'h0, 0, "prbs31");
      inj_mask = 16'h0001;
      prbs_words(6, INJ_LAT, 16'h0001, 1, "inj_bit0");
      check("inj_cnt_one", {16'h0, inj_cnt}, 32'h1);

      // Reset mid-RUN with a request armed: everything clears, no late ack.
      inj_req = 1'b1;
      model_word(w);
      expect_cycle(w, 1'b1, 1'b0, "pre_rst");
      inj_req = 1'b0;
      rst_n   = 1'b0;
      expect_cycle(16'h0, 1'b0, 1'b0, "mid_rst");
      check("mid_rst.inj_cnt", {16'h0, inj_cnt}, 32'h0);
      rst_n = 1'b1;
      start_run();
      model_seed(2'b10, 31'h0123_4567);
      prbs_words(8, -1, 16'h0, 0, "post_rst");

      // Level held for 100 cycles injects once.
      do_reset();
      model_seed(2'b10, 31'h0123_4567);
      start_run();
      inj_mask = 16'h8000;
      prbs_words(110, INJ_LAT, 16'h8000, 100, "inj_hold");
      check("inj_hold.inj_cnt", {16'h0, inj_cnt}, 32'h1);

      // Counter saturation from a preloaded near-full value.
      force dut.inj_cnt_q = 16'hFFFE;
      #1;
      release dut.inj_cnt_q;
      check("cnt_preload", {16'h0, inj_cnt}, 32'h0000_FFFE);
      prbs_words(INJ_LAT + 3, INJ_LAT, 16'h8000, 1, "inj_sat1");
      check("cnt_full", {16'h0, inj_cnt}, 32'h0000_FFFF);
      prbs_words(INJ_LAT + 3, INJ_LAT, 16'h8000, 1, "inj_sat2");
      check("cnt_saturated", {16'h0, inj_cnt}, 32'h0000_FFFF);

      // Reseed and injection together: reseed wins, request fires on the first new word.
      do_reset();
      prbs_sel = 2'b10;
      model_seed(2'b10, 31'h0123_4567);
      start_run();
      prbs_words(3, -1, 16'h0, 0, "prbs31_b");
      inj_mask = 16'h0100;
      prbs_words(1, -1, 16'h0, 1, "reseed_req");
      prbs_sel = 2'b11;
      expect_cycle(16'h0, 1'b0, 1'b0, "reseed_load");
      expect_cycle(16'h0, 1'b0, 1'b0, "reseed_run0");
      model_seed(2'b11, 31'h0123_4567);
      prbs_words(3, 0, 16'h0100, 0, "reseed_inj");
      check("reseed.inj_cnt", {16'h0, inj_cnt}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
